// File: rtl/avl_burst_traffic_gen_if.sv
// ----------------------------------------------------------------------------
// avl_burst_traffic_gen_if
//
// Purpose:
//   Avalon-MM burst bus between the traffic generator (master) and an SDRAM
//   controller slave port (avl_s0).
//
// Signals:
//   address               burst start byte address (master -> slave)
//   byte_en               byte enables, all ones while write is high
//   write / read          write request / read command request
//   write_data            write beat data
//   begin_burst_transfer  first beat / command of a burst
//   burst_count           beats per burst
//   wait_request          slave stall (slave -> master)
//   read_data             read beat data
//   read_data_valid       read beat valid
//   resp_ready            master ready for read beats
//
// Modports: master (generator side), slave (controller / bench side).
// ----------------------------------------------------------------------------
interface avl_burst_traffic_gen_if #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 8
) ();
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byte_en;
    logic                write;
    logic                read;
    logic [DATA_W-1:0]   write_data;
    logic                begin_burst_transfer;
    logic [BURST_W-1:0]  burst_count;
    logic                wait_request;
    logic [DATA_W-1:0]   read_data;
    logic                read_data_valid;
    logic                resp_ready;

    modport master (
        output address, byte_en, write, read, write_data,
               begin_burst_transfer, burst_count, resp_ready,
        input  wait_request, read_data, read_data_valid
    );

    modport slave (
        input  address, byte_en, write, read, write_data,
               begin_burst_transfer, burst_count, resp_ready,
        output wait_request, read_data, read_data_valid
    );
endinterface

// File: rtl/avl_burst_traffic_gen.sv
// ----------------------------------------------------------------------------
// avl_burst_traffic_gen
//
// Purpose:
//   Avalon burst master that writes burst_num bursts of burst_len beats,
//   reads each burst straight back and checks the returned data against a
//   regenerated pattern. Status (busy/done/pass/err_cnt/first_err_addr) is
//   meant for LEDs or an on-chip logic analyser.
//
// Optional feature macro: TRAFFIC_GEN_LFSR_EN
//   Defined     : pattern_sel=1 selects a Galois LFSR pattern (zero seed -> 1).
//   Not defined : incrementing pattern only, pattern_sel is ignored.
//
// Ports:
//   i_clk              system clock
//   i_rest_n           asynchronous active-low reset
//   i_start            start pulse, ignored while busy
//   i_base_addr        first byte address (word aligned)
//   i_burst_len        beats per burst
//   i_burst_num        number of write/read burst pairs
//   i_seed             pattern seed
//   i_pattern_sel      0 = incrementing, 1 = LFSR (macro only)
//   o_busy             run in progress
//   o_done             one-cycle pulse at end of run
//   o_pass             run finished with no mismatches, held until next start
//   o_err_cnt          saturating count of mismatching beats
//   o_first_err_addr   byte address of the first mismatch
//   avl_m0             Avalon burst master port (interface, master modport)
// ----------------------------------------------------------------------------
module avl_burst_traffic_gen #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 8,
    parameter int NUM_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rest_n,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    i_base_addr,
    input  logic [BURST_W-1:0]   i_burst_len,
    input  logic [NUM_W-1:0]     i_burst_num,
    input  logic [DATA_W-1:0]    i_seed,
    input  logic                 i_pattern_sel,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [NUM_W-1:0]     o_err_cnt,
    output logic [ADDR_W-1:0]    o_first_err_addr,
    avl_burst_traffic_gen_if.master avl_m0
);

    localparam int BYTES = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_CMD,
        S_RD_DATA,
        S_NEXT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_W-1:0]  r_burst_addr;
    logic [BURST_W-1:0] r_len;
    logic [NUM_W-1:0]   r_remaining;
    logic [BURST_W-1:0] r_beat;
    logic [DATA_W-1:0]  r_burst_pat;
    logic [DATA_W-1:0]  r_wr_pat;
    logic [DATA_W-1:0]  r_rd_pat;
    logic [NUM_W-1:0]   r_err_cnt;
    logic [ADDR_W-1:0]  r_first_err_addr;
    logic               r_pass;

    logic               w_wr_accept;
    logic               w_rd_accept;
    logic               w_rd_beat;
    logic               w_last_beat;
    logic               w_mismatch;
    logic               w_start_zero;
    logic [ADDR_W-1:0]  w_beat_addr;
    logic [ADDR_W-1:0]  w_burst_bytes;
    logic [DATA_W-1:0]  w_seed_init;

`ifdef TRAFFIC_GEN_LFSR_EN
    // Fixed tap mask; the MSB tap keeps a non-zero state from ever reaching 0.
    localparam logic [DATA_W-1:0] LFSR_TAPS = {1'b1, {(DATA_W-3){1'b0}}, 2'b11};

    logic r_pat_sel;

    assign w_seed_init = (i_pattern_sel && (i_seed == '0)) ? DATA_W'(1) : i_seed;

    function automatic logic [DATA_W-1:0] f_next_pat(input logic [DATA_W-1:0] p);
        if (r_pat_sel) begin
            return p[0] ? ((p >> 1) ^ LFSR_TAPS) : (p >> 1);
        end
        return p + DATA_W'(1);
    endfunction
`else
    logic w_unused_pattern_sel;

    assign w_unused_pattern_sel = i_pattern_sel;
    assign w_seed_init          = i_seed;

    function automatic logic [DATA_W-1:0] f_next_pat(input logic [DATA_W-1:0] p);
        return p + DATA_W'(1);
    endfunction
`endif

    assign w_wr_accept   = (r_state == S_WR) && !avl_m0.wait_request;
    assign w_rd_accept   = (r_state == S_RD_CMD) && !avl_m0.wait_request;
    assign w_rd_beat     = (r_state == S_RD_DATA) && avl_m0.read_data_valid;
    assign w_last_beat   = (r_beat == (r_len - BURST_W'(1)));
    assign w_mismatch    = w_rd_beat && (avl_m0.read_data != r_rd_pat);
    assign w_start_zero  = (i_burst_len == '0) || (i_burst_num == '0);
    assign w_beat_addr   = r_burst_addr + (ADDR_W'(r_beat) * ADDR_W'(BYTES));
    assign w_burst_bytes = ADDR_W'(r_len) * ADDR_W'(BYTES);

    // State register.
    always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. A zero-length run skips straight to DONE so the caller
    // still sees a done pulse.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = w_start_zero ? S_DONE : S_WR;
                end
            end
            S_WR: begin
                if (w_wr_accept && w_last_beat) begin
                    w_next_state = S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                if (w_rd_accept) begin
                    w_next_state = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (w_rd_beat && w_last_beat) begin
                    w_next_state = S_NEXT;
                end
            end
            S_NEXT: begin
                w_next_state = (r_remaining == NUM_W'(1)) ? S_DONE : S_WR;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode. Address and burst count come straight from registers.
    always_comb begin
        avl_m0.write                = 1'b0;
        avl_m0.read                 = 1'b0;
        avl_m0.begin_burst_transfer = 1'b0;
        avl_m0.resp_ready           = 1'b0;
        avl_m0.byte_en              = '0;
        o_busy                      = (r_state != S_IDLE);
        o_done                      = 1'b0;
        case (r_state)
            S_WR: begin
                avl_m0.write                = 1'b1;
                avl_m0.byte_en              = '1;
                avl_m0.begin_burst_transfer = (r_beat == '0);
            end
            S_RD_CMD: begin
                avl_m0.read                 = 1'b1;
                avl_m0.begin_burst_transfer = 1'b1;
            end
            S_RD_DATA: begin
                avl_m0.resp_ready = 1'b1;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign avl_m0.address     = r_burst_addr;
    assign avl_m0.burst_count = r_len;
    assign avl_m0.write_data  = r_wr_pat;

    // pass shows during the done cycle and is then held in r_pass.
    assign o_pass           = r_pass || ((r_state == S_DONE) && (r_err_cnt == '0));
    assign o_err_cnt        = r_err_cnt;
    assign o_first_err_addr = r_first_err_addr;

    // Datapath. r_burst_pat is the generator state at the start of the current
    // burst, so readback replays exactly what was written for that burst.
    always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
            r_burst_addr     <= '0;
            r_len            <= '0;
            r_remaining      <= '0;
            r_beat           <= '0;
            r_burst_pat      <= '0;
            r_wr_pat         <= '0;
            r_rd_pat         <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
`ifdef TRAFFIC_GEN_LFSR_EN
            r_pat_sel        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_burst_addr     <= i_base_addr;
                        r_len            <= i_burst_len;
                        r_remaining      <= i_burst_num;
                        r_beat           <= '0;
                        r_burst_pat      <= w_seed_init;
                        r_wr_pat         <= w_seed_init;
                        r_rd_pat         <= w_seed_init;
                        r_err_cnt        <= '0;
                        r_first_err_addr <= '0;
                        r_pass           <= 1'b0;
`ifdef TRAFFIC_GEN_LFSR_EN
                        r_pat_sel        <= i_pattern_sel;
`endif
                    end
                end
                S_WR: begin
                    if (w_wr_accept) begin
                        r_wr_pat <= f_next_pat(r_wr_pat);
                        if (w_last_beat) begin
                            r_beat   <= '0;
                            r_rd_pat <= r_burst_pat;
                        end else begin
                            r_beat <= r_beat + BURST_W'(1);
                        end
                    end
                end
                S_RD_DATA: begin
                    if (w_rd_beat) begin
                        r_rd_pat <= f_next_pat(r_rd_pat);
                        r_beat   <= w_last_beat ? '0 : (r_beat + BURST_W'(1));
                        if (w_mismatch) begin
                            // err_cnt never returns to zero within a run, so
                            // zero here marks the first mismatch.
                            if (r_err_cnt == '0) begin
                                r_first_err_addr <= w_beat_addr;
                            end
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + NUM_W'(1);
                            end
                        end
                    end
                end
                S_NEXT: begin
                    r_burst_addr <= r_burst_addr + w_burst_bytes;
                    r_remaining  <= r_remaining - NUM_W'(1);
                    r_burst_pat  <= r_wr_pat;
                end
                S_DONE: begin
                    r_pass <= (r_err_cnt == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/avl_burst_traffic_gen.md
Name: avl_burst_traffic_gen

Overview:
Parametrised Avalon burst master that generates write-then-readback traffic into sdram_controller's avl_s0 slave port and checks the returned data. It replaces hand-driven bus stimulus with a self-checking engine: configurable width, burst length, burst count and data pattern. It is used in simulation and in on-board SDRAM bring-up, with status visible on LEDs or in SignalTap.

Parameters:
ADDR_W, 24, Avalon byte-address width
DATA_W, 32, Avalon data width; must be a multiple of 8
BURST_W, 8, burst_count width
NUM_W, 16, width of the burst-number and error counters

Ports:
clk  in  1  system clock
rest_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start pulse; ignored while busy
base_addr  in  ADDR_W  first byte address; aligned to DATA_W/8
burst_len  in  BURST_W  beats per burst
burst_num  in  NUM_W  number of write/read burst pairs
seed  in  DATA_W  pattern seed
pattern_sel  in  1  0 = incrementing, 1 = LFSR (only with the macro)
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  high after a run with err_cnt==0; held until next start
err_cnt  out  NUM_W  mismatching beats, saturating
first_err_addr  out  ADDR_W  byte address of first mismatch
avl_m0_address  out  ADDR_W  burst start address
avl_m0_byte_en  out  DATA_W/8  always all ones while write is high
avl_m0_write  out  1  write request
avl_m0_read  out  1  read request
avl_m0_write_data  out  DATA_W  write beat data
avl_m0_begin_burst_transfer  out  1  high on first beat/command of a burst only
avl_m0_burst_count  out  BURST_W  equals latched burst_len
avl_m0_wait_request  in  1  slave stall
avl_m0_read_data  in  DATA_W  read beat data
avl_m0_read_data_valid  in  1  read beat valid
avl_m0_resp_ready  out  1  high in RD_DATA, otherwise 0

Behaviour:
- Reset, asynchronous: all outputs 0, FSM in IDLE, counters cleared. Reset mid-burst drops write/read immediately; no completion is attempted.
- Start in IDLE: latch base_addr, burst_len, burst_num, seed and pattern_sel.
  - If burst_len==0 or burst_num==0: next cycle done=1 and pass=1, no bus traffic.
  - Otherwise: clear err_cnt, pass and first_err_addr, then go to WR.
- IDLE -> WR:
  - Assert avl_m0_write, with begin_burst_transfer=1 on beat 0 only.
  - Address is held at the burst start for the whole burst.
  - A beat is accepted in a cycle where write && !wait_request; write_data then advances next cycle.
  - After burst_len accepted beats, go to RD_CMD.
- RD_CMD:
  - Assert read and begin_burst_transfer with the same address.
  - Hold until !wait_request (accepted in exactly that cycle), then go to RD_DATA.
- RD_DATA:
  - Each read_data_valid beat is compared against the regenerated pattern for that beat.
  - On a mismatch, err_cnt increments, saturating at 2^NUM_W-1. The first mismatch of the run captures burst_addr + beat*(DATA_W/8).
  - After burst_len valid beats, go to NEXT.
- NEXT:
  - burst_addr += burst_len*(DATA_W/8), wrapping modulo 2^ADDR_W.
  - Decrement the remaining burst count. Back to WR if nonzero, else DONE.
- DONE: for one cycle, done=1 and pass=(err_cnt==0). Then IDLE.
- busy is high in every state except IDLE.
- Pattern for global beat index k (from 0 across the run):
  - Incrementing: seed + k, modulo 2^DATA_W.
  - The readback regenerator restarts from the same state as the write generator for each burst, so the read of burst n expects the write of burst n.
- Valid beats arriving outside RD_DATA are ignored.
- wait_request has no effect while neither read nor write is asserted.

Optional Feature:
TRAFFIC_GEN_LFSR_EN
- Defined: pattern_sel=1 selects a Galois LFSR of width DATA_W, seeded with seed (a zero seed is replaced by 1). The LFSR steps once per accepted write beat and once per valid read beat.
- Not defined: pattern_sel is ignored and the incrementing pattern is always used. There is no LFSR logic.

Test Plan:
- Ideal sdram_controller + sdr model; base 0, burst_len 255, burst_num 4, seed 32'h12345678, incrementing -> 1020 write beats, first word 32'h12345678, done pulse, pass=1, err_cnt=0.
- Slave model with random wait_request (50%) on burst_len 8, burst_num 3 -> write_data held stable while stalled, exactly 24 beats written and read, pass=1.
- Read model corrupting beat 5 of burst 1 (burst_len 16, base 32'h100) -> err_cnt=1, first_err_addr=32'h100+64+20=0x154, pass=0.
- base_addr = 2^24-32, burst_len 8, burst_num 2 -> second burst address wraps to 0x000000.
- burst_len 0 -> done next cycle, pass=1, no write/read ever asserted. Also: rest_n pulsed low mid-WR -> write deasserted asynchronously, busy=0.
- With TRAFFIC_GEN_LFSR_EN, pattern_sel 1, seed 0 -> first beat 1, pass=1. Without the macro, the same run produces the incrementing pattern starting at 0.
